fetch_prefetch_unit: RTL and testbench

//  IF stage of the 5-stage RV32 pipeline: drives the instruction-memory request/response port,

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_prefetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc, instr} entries with flush and
// same-edge push/pop support.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot a push into a full buffer needs.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// IF stage: credit-limited instruction prefetch with in-order response
// tracking, redirect discard and the IF/ID pipeline register.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stalld,
  output logic [XLEN-1:0] instrd,
  output logic [XLEN-1:0] pcd,
  output logic [XLEN-1:0] pcplus4d,
  output logic            validd
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_use;
  logic            accept;
  logic            drop_rsp;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_empty;
  fetch_entry_t    fifo_wr;
  fetch_entry_t    fifo_head;

  assign target = word_align(redirect_pc);

  // Buffered plus in-flight fetches may never exceed the buffer size, so
  // every response has a guaranteed slot and the FIFO cannot overflow.
  assign in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req_valid = reset & (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  assign drop_rsp   = (discard != '0);
  assign fifo_push  = imem_rsp_valid & ~drop_rsp & ~redirect;
  assign fifo_pop   = ~redirect & ~stalld & ~fifo_empty;
  assign fifo_wr.pc    = rsp_pc;
  assign fifo_wr.instr = imem_rsp_data;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .flush    (redirect),
    .wr_entry (fifo_wr),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= target;
        rsp_pc   <= target;
        discard  <= outstanding_next;
      end else begin
        if (accept)                      fetch_pc <= fetch_pc + PC_STEP;
        if (fifo_push)                   rsp_pc   <= rsp_pc + PC_STEP;
        if (imem_rsp_valid && drop_rsp)  discard  <= discard - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrd   <= NOP_INSTR;
      pcd      <= '0;
      pcplus4d <= '0;
      validd   <= 1'b0;
    end else if (redirect) begin
      instrd <= NOP_INSTR;
      validd <= 1'b0;
    end else if (!stalld) begin
      if (!fifo_empty) begin
        instrd   <= fifo_head.instr;
        pcd      <= fifo_head.pc;
        pcplus4d <= fifo_head.pc + PC_STEP;
        validd   <= 1'b1;
      end else begin
        instrd <= NOP_INSTR;
        validd <= 1'b0;
      end
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (!reset)
    in_use <= (CW+1)'(DEPTH));
  a_discard: assert property (@(posedge clk) disable iff (!reset)
    discard <= outstanding);
  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: behavioural imem with
// configurable latency returning the address as data, plus a pc scoreboard.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stalld;
  logic [31:0] instrd;
  logic [31:0] pcd;
  logic [31:0] pcplus4d;
  logic        validd;

  always #5 clk = ~clk;

  fetch_prefetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .stalld        (stalld),
    .instrd        (instrd),
    .pcd           (pcd),
    .pcplus4d      (pcplus4d),
    .validd        (validd)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] sb[$];
  int unsigned cyc;
  int unsigned mem_lat;
  logic [31:0] exp_addr;
  int          checks;
  int          failures;
  logic [31:0] prev_instr, prev_pc, prev_p4;
  logic        prev_valid;
  logic        loaded;
  logic [31:0] loaded_pc, loaded_p4;
  logic        saw_acc, saw_rsp;

  // One clock: present imem response, sample accept, clock, update model, check IF/ID.
  task automatic step();
    logic        acc;
    logic [31:0] acc_addr;
    logic        was_redirect, was_stall, was_reset;
    logic [31:0] e;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (reset && memq.size() > 0 && memq[0].due <= cyc + 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memq[0].addr;
    end
    #3;
    acc          = imem_req_valid & imem_req_ready;
    acc_addr     = imem_req_addr;
    was_redirect = redirect;
    was_stall    = stalld;
    was_reset    = ~reset;
    saw_acc      = acc;
    saw_rsp      = imem_rsp_valid;
    @(posedge clk);
    cyc++;
    if (was_reset) begin
      memq.delete();
      sb.delete();
    end else begin
      if (imem_rsp_valid) void'(memq.pop_front());
      if (acc) begin
        memq.push_back('{addr: acc_addr, due: cyc + mem_lat});
        checks++;
        if (acc_addr !== exp_addr) begin
          failures++;
          $display("FAIL req_addr: got %h expected %h", acc_addr, exp_addr);
        end
        if (!was_redirect) sb.push_back(exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      if (was_redirect) begin
        sb.delete();
        exp_addr = {redirect_pc[31:2], 2'b00};
      end
    end
    #1;
    loaded = 1'b0;
    if (!was_reset) begin
      if (was_redirect) begin
        checks++;
        if (validd !== 1'b0 || instrd !== NOP) begin
          failures++;
          $display("FAIL redirect_flush: got valid=%b instr=%h expected valid=0 instr=%h",
                   validd, instrd, NOP);
        end
      end else if (was_stall) begin
        checks++;
        if ({validd, instrd, pcd, pcplus4d} !== {prev_valid, prev_instr, prev_pc, prev_p4}) begin
          failures++;
          $display("FAIL stall_hold: got %b/%h/%h/%h expected %b/%h/%h/%h",
                   validd, instrd, pcd, pcplus4d, prev_valid, prev_instr, prev_pc, prev_p4);
        end
      end else if (validd === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_instr: got pc=%h expected no instruction", pcd);
        end else begin
          e = sb.pop_front();
          if (pcd !== e || instrd !== e || pcplus4d !== e + 32'd4) begin
            failures++;
            $display("FAIL ifid_data: got pc=%h instr=%h p4=%h expected pc=%h instr=%h p4=%h",
                     pcd, instrd, pcplus4d, e, e, e + 32'd4);
          end
          loaded    = 1'b1;
          loaded_pc = pcd;
          loaded_p4 = pcplus4d;
        end
      end else begin
        checks++;
        if (validd !== 1'b0 || instrd !== NOP) begin
          failures++;
          $display("FAIL bubble: got valid=%b instr=%h expected valid=0 instr=%h",
                   validd, instrd, NOP);
        end
      end
      checks++;
      if (sb.size() > DEPTH) begin
        failures++;
        $display("FAIL credit: got %0d pending expected <= %0d", sb.size(), DEPTH);
      end
    end
    prev_valid = validd;
    prev_instr = instrd;
    prev_pc    = pcd;
    prev_p4    = pcplus4d;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect       = 1'b0;
    redirect_pc    = '0;
    stalld         = 1'b0;
    mem_lat        = 1;
    cyc            = 0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_req: got valid=%b addr=%h expected valid=0 addr=%h",
               imem_req_valid, imem_req_addr, RESET_PC);
    end
    checks++;
    if (validd !== 1'b0 || instrd !== NOP || pcd !== 32'h0 || pcplus4d !== 32'h0) begin
      failures++;
      $display("FAIL reset_ifid: got %b/%h/%h/%h expected 0/%h/0/0",
               validd, instrd, pcd, pcplus4d, NOP);
    end
    @(posedge clk);
    #1;
    step();
    step();
  endtask

  task automatic test_stream();
    logic [2:0] vseq;
    reset    = 1'b1;
    exp_addr = RESET_PC;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL first_req: got valid=%b addr=%h expected valid=1 addr=%h",
               imem_req_valid, imem_req_addr, RESET_PC);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vseq[i] = validd;
    end
    checks++;
    if (vseq !== 3'b100) begin
      failures++;
      $display("FAIL first_valid_latency: got edge-valid %b expected 100", vseq);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (!loaded) begin
        failures++;
        $display("FAIL throughput: got no load at cycle %0d expected one per cycle", i);
      end
    end
  endtask

  task automatic test_stall();
    stalld = 1'b1;
    repeat (6) step();
    checks++;
    if (imem_req_valid !== 1'b0 || sb.size() != DEPTH) begin
      failures++;
      $display("FAIL stall_credit: got req_valid=%b pending=%0d expected req_valid=0 pending=%0d",
               imem_req_valid, sb.size(), DEPTH);
    end
    stalld = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_redirect_latency();
    mem_lat = 3;
    repeat (8) step();
    checks++;
    if (memq.size() == 0) begin
      failures++;
      $display("FAIL inflight_before_redirect: got 0 expected >0");
    end
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    loaded   = 1'b0;
    for (int i = 0; i < 40 && !loaded; i++) step();
    checks++;
    if (!loaded || loaded_pc !== 32'h100) begin
      failures++;
      $display("FAIL redirect_target: got loaded=%b pc=%h expected pc=00000100", loaded, loaded_pc);
    end
    repeat (8) step();
    mem_lat = 1;
    repeat (4) step();
  endtask

  task automatic test_redirect_accept_rsp();
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 64 && imem_req_addr !== 32'h20; i++) step();
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    checks++;
    if (saw_acc !== 1'b1 || saw_rsp !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_setup: got acc=%b rsp=%b expected acc=1 rsp=1", saw_acc, saw_rsp);
    end
    checks++;
    if (imem_req_addr !== 32'h200) begin
      failures++;
      $display("FAIL post_redirect_addr: got %h expected 00000200", imem_req_addr);
    end
    loaded = 1'b0;
    for (int i = 0; i < 20 && !loaded; i++) step();
    checks++;
    if (!loaded || loaded_pc !== 32'h200) begin
      failures++;
      $display("FAIL restart_pc: got loaded=%b pc=%h expected 00000200", loaded, loaded_pc);
    end
    step();
    checks++;
    if (!loaded || loaded_pc !== 32'h204) begin
      failures++;
      $display("FAIL restart_next: got loaded=%b pc=%h expected 00000204", loaded, loaded_pc);
    end
    repeat (4) step();
  endtask

  task automatic test_wrap();
    logic [31:0] want[3];
    int unsigned n;
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    n = 0;
    for (int i = 0; i < 30 && n < 3; i++) begin
      step();
      if (loaded) begin
        checks++;
        if (loaded_pc !== want[n]) begin
          failures++;
          $display("FAIL wrap_pc: got %h expected %h", loaded_pc, want[n]);
        end
        if (n == 1) begin
          checks++;
          if (loaded_p4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pcplus4: got %h expected 00000000", loaded_p4);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL wrap_timeout: got %0d loads expected 3", n);
    end
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    stalld = 1'b1;
    repeat (6) step();
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL midreset_req: got valid=%b addr=%h expected valid=0 addr=%h",
               imem_req_valid, imem_req_addr, RESET_PC);
    end
    checks++;
    if (validd !== 1'b0 || instrd !== NOP || pcd !== 32'h0 || pcplus4d !== 32'h0) begin
      failures++;
      $display("FAIL midreset_ifid: got %b/%h/%h/%h expected 0/%h/0/0",
               validd, instrd, pcd, pcplus4d, NOP);
    end
    stalld = 1'b0;
    step();
    step();
    reset    = 1'b1;
    exp_addr = RESET_PC;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      failures++;
      $display("FAIL restart_req: got valid=%b addr=%h expected valid=1 addr=%h",
               imem_req_valid, imem_req_addr, RESET_PC);
    end
    loaded = 1'b0;
    for (int i = 0; i < 10 && !loaded; i++) step();
    checks++;
    if (!loaded || loaded_pc !== RESET_PC) begin
      failures++;
      $display("FAIL restart_first: got loaded=%b pc=%h expected %h", loaded, loaded_pc, RESET_PC);
    end
    repeat (6) step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_accept_rsp();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
